// File: rtl/pout_pkg.sv
// Shared helpers for the pin-output serializer: width math, entry sizing and
// the parameter legality rule used to stop elaboration of bad configurations.
package pout_pkg;

  // Ceiling log2 with a floor of 1 so every counter has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < value) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int beats(input int data_width, input int pin_width);
    return data_width / pin_width;
  endfunction

  // FIFO entries carry the word plus the upstream end-of-frame flag.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

  function automatic bit params_legal(input int data_width, input int pin_width,
                                      input int frame_len, input int fifo_depth);
    return (pin_width > 0) && (data_width >= pin_width) &&
           ((data_width % pin_width) == 0) && (frame_len >= 2) &&
           (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/pout_word_fifo.sv
// Power-of-two word FIFO; not_full is registered so the write side never sees
// a combinational path from the read side.
module pout_word_fifo
  import pout_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_push  = push && not_full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      // A pop while full only frees the slot from the next cycle on.
      not_full <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pout_stream_serializer.sv
// Spectrometer result words to mprj_io pin beats: buffered, width-generic,
// runtime byte order, frame-last generation and framing checks.
module pout_stream_serializer
  import pout_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PIN_WIDTH  = 8,
  parameter int FRAME_LEN  = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIN_WIDTH-1:0]  out_data,
  output logic                  out_last,
  input  logic                  cfg_msb_first,
  input  logic                  err_clr,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt
);

  localparam int BEATS = beats(DATA_WIDTH, PIN_WIDTH);
  localparam int BW    = clog2(BEATS);
  localparam int WCW   = clog2(FRAME_LEN);
  localparam int EW    = entry_width(DATA_WIDTH);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_LEN - 1);

  if (!params_legal(DATA_WIDTH, PIN_WIDTH, FRAME_LEN, FIFO_DEPTH)) begin : g_param_check
    $error("pout_stream_serializer: illegal DATA_WIDTH/PIN_WIDTH/FRAME_LEN/FIFO_DEPTH");
  end

  // Both sides use valid/ready: a transfer happens on a rising clock edge where
  // valid and ready are both high; once valid is raised, the payload holds
  // until that edge, and ready never depends combinationally on valid.

  logic [EW-1:0]         fifo_data;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_last;
  logic [BW-1:0]         beat;
  logic [WCW-1:0]        word_cnt;
  logic [WCW-1:0]        word_cnt_next;
  logic                  msb_q;
  logic                  valid_q;
  logic                  fire;
  logic                  beat_last;
  logic                  word_last;
  logic                  word_done;
  logic                  load;

  pout_word_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (in_valid && in_ready),
    .push_data ({in_last, in_data}),
    .pop       (load),
    .pop_data  (fifo_data),
    .not_full  (in_ready),
    .empty     (fifo_empty)
  );

  assign out_valid = valid_q;
  assign beat_last = (beat == LAST_BEAT);
  assign word_last = (word_cnt == LAST_WORD);
  assign fire      = valid_q && out_ready;
  assign word_done = fire && beat_last;
  // Reload on the last beat's fire so back-to-back words stream without a bubble.
  assign load      = !fifo_empty && (!valid_q || word_done);
  assign out_last  = valid_q && beat_last && word_last;

  always_comb begin
    word_cnt_next = word_cnt;
    if (word_done) word_cnt_next = word_last ? '0 : word_cnt + WCW'(1);
  end

  always_comb begin
    int slice_sel;
    slice_sel = msb_q ? (BEATS - 1 - int'(beat)) : int'(beat);
    out_data  = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (slice_sel == i) out_data = hold[i*PIN_WIDTH +: PIN_WIDTH];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hold      <= '0;
      hold_last <= 1'b0;
      beat      <= '0;
      word_cnt  <= '0;
      msb_q     <= 1'b0;
      valid_q   <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      word_cnt <= word_cnt_next;
      if (load) begin
        hold      <= fifo_data[DATA_WIDTH-1:0];
        hold_last <= fifo_data[DATA_WIDTH];
        beat      <= '0;
        valid_q   <= 1'b1;
        // Byte order is frozen for the whole frame at its first word.
        if (word_cnt_next == '0) msb_q <= cfg_msb_first;
      end else if (word_done) begin
        valid_q <= 1'b0;
        beat    <= '0;
      end else if (fire) begin
        beat <= beat + BW'(1);
      end
      if (word_done && (hold_last != word_last)) frame_err <= 1'b1;
      else if (err_clr)                          frame_err <= 1'b0;
      if (fire && out_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pout_stream_serializer.sv
// Directed bench for pout_stream_serializer: 16/8 frame tests with a beat
// scoreboard, plus 32/8 and 8/8 instances for the width sweep.
module tb_pout_stream_serializer;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  // ---------------- main DUT (16/8, FRAME_LEN=4) ----------------
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic        cfg_msb_first, err_clr, frame_err;
  logic [15:0] frame_cnt;

  pout_stream_serializer #(.DATA_WIDTH(16), .PIN_WIDTH(8), .FRAME_LEN(4), .FIFO_DEPTH(4)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .cfg_msb_first(cfg_msb_first),
    .err_clr(err_clr), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // ---------------- sweep DUT b (32/8) ----------------
  logic        b_in_valid, b_in_ready, b_in_last;
  logic [31:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_out_data;
  logic        b_cfg, b_err_clr, b_frame_err;
  logic [15:0] b_frame_cnt;

  pout_stream_serializer #(.DATA_WIDTH(32), .PIN_WIDTH(8), .FRAME_LEN(4), .FIFO_DEPTH(4)) dut_b (
    .clock(clock), .resetn(resetn), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .cfg_msb_first(b_cfg),
    .err_clr(b_err_clr), .frame_err(b_frame_err), .frame_cnt(b_frame_cnt)
  );

  // ---------------- sweep DUT c (8/8, FRAME_LEN=2) ----------------
  logic        c_in_valid, c_in_ready, c_in_last;
  logic [7:0]  c_in_data;
  logic        c_out_valid, c_out_ready, c_out_last;
  logic [7:0]  c_out_data;
  logic        c_cfg, c_err_clr, c_frame_err;
  logic [15:0] c_frame_cnt;

  pout_stream_serializer #(.DATA_WIDTH(8), .PIN_WIDTH(8), .FRAME_LEN(2), .FIFO_DEPTH(4)) dut_c (
    .clock(clock), .resetn(resetn), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_last(c_out_last), .cfg_msb_first(c_cfg),
    .err_clr(c_err_clr), .frame_err(c_frame_err), .frame_cnt(c_frame_cnt)
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];     // {expected out_last, expected beat}
  int         exp_widx = 0; // bench's own word position within the frame
  logic       mon_en = 1'b0;
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       stall_last = 1'b0;
  logic       prev_fire = 1'b0;
  int         run_len = 0;
  logic [8:0] exp_e;
  logic [7:0] b_exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat monitor: scoreboard on every fire, stability on every stall.
  always @(negedge clock) begin
    if (mon_en) begin
      if (stall_q) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, stall_data);
        check("stall_last", out_last, stall_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
        else begin
          exp_e = exp_q.pop_front();
          check("beat_data", out_data, exp_e[7:0]);
          check("beat_last", out_last, exp_e[8]);
        end
        run_len = prev_fire ? run_len + 1 : 1;
      end
      prev_fire  = out_valid && out_ready;
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end else begin
      stall_q   = 1'b0;
      prev_fire = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [15:0] d, input logic l);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      done = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) check("push_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [15:0] d, input logic l, input logic msb);
    logic lf;
    lf = (exp_widx == 3);
    if (msb) begin
      exp_q.push_back({1'b0, d[15:8]});
      exp_q.push_back({lf, d[7:0]});
    end else begin
      exp_q.push_back({1'b0, d[7:0]});
      exp_q.push_back({lf, d[15:8]});
    end
    exp_widx = (exp_widx + 1) % 4;
    push_word(d, l);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) check("valid_timeout", out_valid, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    resetn = 1'b1;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    cfg_msb_first = 0; err_clr = 0;
    b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 0; b_cfg = 0; b_err_clr = 0;
    c_in_valid = 0; c_in_data = 0; c_in_last = 0; c_out_ready = 0; c_cfg = 0; c_err_clr = 0;
    #1 resetn = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    check("ready_pre_edge", in_ready, 0);
    @(posedge clock); #1;
    check("ready_after_release", in_ready, 1);

    // Frame 1: LSB first, continuous streaming
    mon_en = 1'b1;
    out_ready = 1'b1;
    send(16'h1234, 0, 0);
    send(16'hABCD, 0, 0);
    send(16'h0001, 0, 0);
    send(16'h8000, 1, 0);
    wait_drain();
    check("t1_consecutive", run_len, 8);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_frame_err", frame_err, 0);
    check("t1_idle", out_valid, 0);

    // Frame 2 MSB first, cfg dropped mid-frame; frame 3 picks up LSB
    cfg_msb_first = 1'b1;
    send(16'h1234, 0, 1);
    send(16'hABCD, 0, 1);
    cfg_msb_first = 1'b0;
    send(16'h0001, 0, 1);
    send(16'h8000, 1, 1);
    send(16'h5566, 0, 0);
    send(16'h7788, 0, 0);
    send(16'h99AA, 0, 0);
    send(16'hBBCC, 1, 0);
    wait_drain();
    check("t2_frame_cnt", frame_cnt, 3);
    check("t2_frame_err", frame_err, 0);

    // Backpressure: hold register plus four FIFO entries, then toggled ready
    out_ready = 1'b0;
    send(16'h1111, 0, 0);
    send(16'h2222, 0, 0);
    send(16'h3333, 0, 0);
    send(16'h4444, 1, 0);
    send(16'h5555, 0, 0);
    @(negedge clock);
    check("full_ready", in_ready, 0);
    check("full_valid", out_valid, 1);
    repeat (3) begin
      @(negedge clock);
      check("full_hold_ready", in_ready, 0);
    end
    @(posedge clock); #1;
    fork
      begin
        send(16'h6666, 0, 0);
        send(16'h7777, 0, 0);
        send(16'h8888, 1, 0);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clock);
          #1 out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check("t3_frame_cnt", frame_cnt, 5);
    check("t3_frame_err", frame_err, 0);

    // Framing errors: early last, missing last, clear, set-beats-clear
    send(16'h0102, 0, 0);
    send(16'h0304, 1, 0);
    wait_drain();
    check("err_early", frame_err, 1);
    pulse_clr();
    check("err_clr_1", frame_err, 0);
    send(16'h0506, 0, 0);
    send(16'h0708, 0, 0);
    wait_drain();
    check("err_missing", frame_err, 1);
    pulse_clr();
    check("err_clr_2", frame_err, 0);
    out_ready = 1'b0;
    send(16'h0A0B, 1, 0);
    wait_valid();
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("err_before", frame_err, 0);
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    check("err_set_wins", frame_err, 1);
    send(16'h0C0D, 0, 0);
    send(16'h0E0F, 0, 0);
    send(16'h1011, 1, 0);
    wait_drain();
    check("t4_err_held", frame_err, 1);
    pulse_clr();
    check("err_clr_3", frame_err, 0);
    check("t4_frame_cnt", frame_cnt, 7);

    // Reset mid-frame after three beats
    mon_en = 1'b0;
    out_ready = 1'b0;
    push_word(16'h1122, 0);
    push_word(16'h3344, 0);
    wait_valid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("pre_rst_beat", out_data, (i == 0) ? 8'h22 : (i == 1) ? 8'h11 : 8'h44);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    @(posedge clock); #1 resetn = 1'b1;
    exp_q.delete();
    exp_widx = 0;
    mon_en = 1'b1;
    out_ready = 1'b1;
    send(16'hC001, 0, 0);
    send(16'hC002, 0, 0);
    send(16'hC003, 0, 0);
    send(16'hC004, 1, 0);
    wait_drain();
    check("t5_frame_cnt", frame_cnt, 1);
    check("t5_frame_err", frame_err, 0);

    // 32/8 sweep
    b_out_ready = 1'b1;
    b_in_data = 32'hDEADBEEF;
    b_in_valid = 1'b1;
    @(negedge clock);
    check("b_ready", b_in_ready, 1);
    @(posedge clock); #1 b_in_valid = 1'b0;
    for (int i = 0; i < 10 && !b_out_valid; i++) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      check("b_beat", b_out_data, b_exp[k]);
      check("b_last", b_out_last, 0);
      @(negedge clock);
    end
    check("b_idle", b_out_valid, 0);
    check("b_frame_cnt", b_frame_cnt, 0);
    check("b_frame_err", b_frame_err, 0);

    // 8/8 sweep: one beat per word, two-cycle latency
    @(posedge clock); #1;
    c_out_ready = 1'b1;
    check("c_ready", c_in_ready, 1);
    c_in_data = 8'h5A; c_in_last = 1'b0; c_in_valid = 1'b1;
    for (lat = 1; lat <= 10; lat++) begin
      @(posedge clock); #1;
      c_in_valid = 1'b0;
      if (c_out_valid) break;
    end
    check("c_latency_1", lat, 2);
    check("c_data_1", c_out_data, 8'h5A);
    check("c_last_1", c_out_last, 0);
    c_in_data = 8'hA5; c_in_last = 1'b1; c_in_valid = 1'b1;
    for (lat = 1; lat <= 10; lat++) begin
      @(posedge clock); #1;
      c_in_valid = 1'b0;
      c_in_last = 1'b0;
      if (c_out_valid) break;
    end
    check("c_latency_2", lat, 2);
    check("c_data_2", c_out_data, 8'hA5);
    check("c_last_2", c_out_last, 1);
    @(posedge clock); #1;
    check("c_idle", c_out_valid, 0);
    check("c_frame_cnt", c_frame_cnt, 1);
    check("c_frame_err", c_frame_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pout_stream_serializer.md
Name: pout_stream_serializer

Overview:
- Parametrised pin-output stage for the spectrometer chain. It takes DATA_WIDTH-bit result words (magnitude/accumulator output) over a ready/valid stream and sends them out as PIN_WIDTH-bit beats on mprj_io pins.
- Generalises the fixed 16-bit-over-8-pin, LSB-first output path:
  - configurable widths;
  - input buffering;
  - runtime byte order;
  - frame-last pin generation;
  - frame-length checking.

Parameters:
- DATA_WIDTH, 16, width of input words; must be an integer multiple of PIN_WIDTH.
- PIN_WIDTH, 8, width of the output pin bus.
- FRAME_LEN, 512, words per frame (FFT size); ≥2.
- FIFO_DEPTH, 4, input word FIFO entries; power of two, ≥2.

Ports:
- clock, input, 1, system clock.
- resetn, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, FIFO can accept a word.
- in_data, input, DATA_WIDTH, input word.
- in_last, input, 1, upstream end-of-frame marker.
- out_valid, output, 1, pin beat valid.
- out_ready, input, 1, pin-side consumer ready.
- out_data, output, PIN_WIDTH, pin beat.
- out_last, output, 1, high on the final beat of the final word of a frame.
- cfg_msb_first, input, 1, 0 = least-significant slice first, 1 = most-significant slice first. Sampled only at frame start.
- err_clr, input, 1, clears frame_err.
- frame_err, output, 1, sticky framing-mismatch flag.
- frame_cnt, output, 16, completed frames, wraps at 2^16.

Behaviour:
- Constants:
  - BEATS = DATA_WIDTH/PIN_WIDTH.
  - beat index width clog2(BEATS), minimum 1.
  - word counter width clog2(FRAME_LEN).
- Reset (asynchronous, resetn low):
  - in_ready=0 during reset, 1 on the first cycle after release (FIFO empty).
  - out_valid=0, out_data=0, out_last=0, frame_err=0, frame_cnt=0.
  - FIFO pointers, beat index and word counter = 0.
  - Latched msb mode = 0.
  - Reset mid-frame discards all buffered and partially sent data.
- Input side:
  - push when in_valid && in_ready; the FIFO stores {in_last, in_data}.
  - in_ready = !full, registered from FIFO state.
  - No combinational in→out pass-through.
  - When full, a simultaneous pop does not raise in_ready in the same cycle.
- Serializer:
  - Holding register plus beat index.
  - When idle (out_valid=0) and the FIFO is non-empty, pop into the holding register; out_valid rises the next cycle.
  - Latency from a push into an empty FIFO to the first out_valid is 2 cycles.
  - out_data for LSB mode = word[(beat+1)*PIN_WIDTH-1 : beat*PIN_WIDTH].
  - out_data for MSB mode = slice (BEATS-1-beat).
  - Beat fire = out_valid && out_ready. On fire, beat increments.
  - On the fire of beat BEATS-1:
    - if the FIFO is non-empty, pop the next word in the same cycle with no bubble (continuous streaming at 1 beat/cycle);
    - otherwise out_valid falls.
  - out_valid, out_data and out_last are held stable while out_ready=0.
- Frame handling:
  - The word counter increments on each completed word (last-beat fire) and wraps to 0 after FRAME_LEN-1.
  - out_last = out_valid && beat==BEATS-1 && word_cnt==FRAME_LEN-1.
  - The internal counter governs out_last; in_last is advisory.
  - frame_cnt increments on the out_last fire.
  - cfg_msb_first is latched when a word is loaded with word_cnt==0 and beat==0, and held for the whole frame.
- Frame error:
  - frame_err is set when a completed word's stored last flag ≠ (word_cnt==FRAME_LEN-1). This covers both early and missing in_last.
  - err_clr clears frame_err. If a set and a clear occur in the same cycle, set wins.
- BEATS=1 degenerates to a registered pass-through with the same FIFO and frame logic.

Decomposition:
- Shared package pout_pkg:
  - clog2 function;
  - BEATS derivation;
  - parameter legality checks (DATA_WIDTH % PIN_WIDTH == 0, FIFO_DEPTH a power of two), failing elaboration when violated;
  - entry-type width DATA_WIDTH+1.
- One sub-module: pout_word_fifo (synchronous FIFO, full/empty flags, asynchronous active-low reset).
- Serializer and frame logic stay in the top level.

Test Plan:
- Reset release, defaults (16/8, FRAME_LEN=4), LSB mode:
  - push 0x1234, 0xABCD, 0x0001, 0x8000 (last on the 4th), out_ready=1;
  - beats 34,12,CD,AB,01,00,00,80 on consecutive cycles;
  - out_last only on beat 80; frame_cnt=1; frame_err=0.
- cfg_msb_first=1 for a frame, toggled to 0 mid-frame:
  - beats 12,34,AB,CD,00,01,80,00;
  - mode changes only at the next frame.
- Backpressure:
  - out_ready toggled every cycle, FIFO filled to 4;
  - in_ready=0 while full; no beat lost or duplicated; outputs stable while stalled.
- Framing error:
  - in_last on the 2nd word of a 4-word frame → frame_err=1 after that word completes;
  - err_clr pulse → 0;
  - err_clr coincident with a new mismatch → stays 1.
- Reset mid-frame after 3 beats:
  - out_valid=0 immediately; FIFO empty;
  - the next frame starts at word_cnt=0 with the correct out_last position.
- Parameter sweep DATA_WIDTH=32/PIN_WIDTH=8 and 8/8:
  - 0xDEADBEEF LSB mode → EF,BE,AD,DE;
  - 8/8 case: 1 beat/word, 2-cycle latency.
